// File: rtl/serial_alu_ctrl_pkg.sv
// Purpose: shared op and FSM encodings for the serial ALU controller and its bit-slice cell.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_alu_ctrl_pkg;

  // Operation codes as presented on the op port.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_AND = 2'd1,
    OP_NOT = 2'd2,
    OP_ILL = 2'd3
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/one_bit_ALU.sv
// Purpose: one-bit ALU slice (add / and / not-a) used as the serial datapath.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, carry_in -> operand bits and incoming carry; op -> operation;
//        y -> result bit; carry_out -> slice carry (0 for everything but add).
module one_bit_ALU
  import serial_alu_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic carry_in,
  input  op_e  op,
  output logic y,
  output logic carry_out
);

  always_comb begin
    y         = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_ADD: begin
        y         = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
      end
      OP_AND:  y = a & b;
      OP_NOT:  y = ~a;
      default: begin
        y         = 1'b0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Purpose: bit-serial ALU controller; one result bit per cycle, LSB first, via one_bit_ALU.
// Latency: done on the (WIDTH+1)th rising edge counting the start-sampling edge; 1st edge for op=3.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.
// Ports: clk, rst (async, active high); start/op/a/b/c_in -> request and operands;
//        busy (RUN), done (one-cycle pulse), result/c_out/err -> registered outcome.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  op_e              op_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             slice_y;
  logic             slice_c;
  op_e              op_in;

  assign op_in = op_e'(op);

  one_bit_ALU u_slice (
    .a         (a_r[cnt]),
    .b         (b_r[cnt]),
    .carry_in  (carry),
    .op        (op_r),
    .y         (slice_y),
    .carry_out (slice_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          // An illegal op has nothing to compute, so it skips straight to DONE.
          state_nxt = (op_in == OP_ILL) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_ADD;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      c_out  <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op_in;
            cnt    <= '0;
            // Carry-in only matters for add; keeping it 0 otherwise means the
            // serial carry never carries stale state into and/not.
            carry  <= (op_in == OP_ADD) ? c_in : 1'b0;
            result <= '0;
            c_out  <= 1'b0;
            err    <= (op_in == OP_ILL);
          end
        end
        S_RUN: begin
          result[cnt] <= slice_y;
          carry       <= slice_c;
          if (cnt == LAST_BIT) begin
            // Counter parks on the last bit; it is cleared by the next start.
            c_out <= slice_c;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Purpose: self-checking bench for serial_alu_ctrl (WIDTH=8) against an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_alu_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             err;

  int checks   = 0;
  int failures = 0;

  serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {err, c_out, result} straight from the arithmetic definition.
  function automatic logic [WIDTH+1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y, input logic ci);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    case (o)
      2'd0:    return {1'b0, s};
      2'd1:    return {2'b00, x & y};
      2'd2:    return {2'b00, ~x};
      default: return {1'b1, 1'b0, {WIDTH{1'b0}}};
    endcase
  endfunction

  // Issue one operation, optionally re-asserting start (op=and) after edge mid_start,
  // and check latency, busy behaviour, outputs and their hold after done.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input int mid_start);
    logic [WIDTH+1:0] exp;
    int               edges;
    logic             busy_first;
    logic             busy_seen;
    exp = model(o, x, y, ci);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; c_in = ci;
    @(posedge clk); #1;
    edges = 1;
    start = 1'b0;
    // Scramble inputs to show the operands were captured.
    op = 2'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
    busy_first = busy;
    busy_seen  = busy;
    while (!done && edges < 3 * WIDTH) begin
      if (edges == mid_start) begin
        start = 1'b1;
        op    = 2'd1;
      end
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      busy_seen = busy_seen | busy;
    end
    check("latency", edges, (o == 2'd3) ? 1 : WIDTH + 1);
    check("busy_first", busy_first, (o != 2'd3));
    check("busy_seen", busy_seen, (o != 2'd3));
    check("busy_at_done", busy, 0);
    check("result", result, exp[WIDTH-1:0]);
    check("c_out", c_out, exp[WIDTH]);
    check("err", err, exp[WIDTH+1]);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("result_hold", result, exp[WIDTH-1:0]);
    check("c_out_hold", c_out, exp[WIDTH]);
    check("err_hold", err, exp[WIDTH+1]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; c_in = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_c_out", c_out, 0);
    check("rst_err", err, 0);
    #5 rst = 1'b0;

    // Directed cases.
    run_op(2'd0, 8'hFF, 8'h01, 1'b0, -1);
    run_op(2'd1, 8'hF0, 8'h3C, 1'b1, -1);
    run_op(2'd2, 8'hA5, 8'h00, 1'b1, -1);
    run_op(2'd3, 8'h12, 8'h34, 1'b1, -1);
    run_op(2'd0, 8'h10, 8'h20, 1'b0, 3);

    // Reset in the middle of RUN: everything drops at once and no done follows.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 8'h55; b = 8'h0F; c_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_run_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_c_out", c_out, 0);
    check("arst_err", err, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", done, 0);
    end

    // Start on the first edge after reset release.
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    run_op(2'd0, 8'h7F, 8'h01, 1'b1, -1);

    // Randomized operations, some with a stray start during the run.
    for (int n = 0; n < 24; n++) begin
      run_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, WIDTH + 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin one operation; sampled in IDLE only.
REQ-005 SHALL have port: op  input  2  operation: 0 = add, 1 = and, 2 = not(a), 3 = illegal.
REQ-006 SHALL have port: a  input  WIDTH  operand A; captured on an accepted start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; captured on an accepted start.
REQ-008 SHALL have port: c_in  input  1  carry-in for add; captured on an accepted start.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress (RUN state).
REQ-010 SHALL have port: done  output  1  one-cycle pulse when result/c_out/err become valid.
REQ-011 SHALL have port: result  output  WIDTH  registered operation result.
REQ-012 SHALL have port: c_out  output  1  final carry of add; 0 for all other ops.
REQ-013 SHALL have port: err  output  1  high with done when the captured op was 3.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1, capture a, b, op, c_in, clear bit counter, and go to RUN (op 0..2) or DONE (op 3).
REQ-016 SHALL ignore start in RUN and DONE; captured operands SHALL NOT change until the next accepted start.
REQ-017 SHALL, in RUN, process exactly one bit per cycle, LSB first: bit i of result = one-bit ALU output for (a[i], b[i], carry, op).
REQ-018 SHALL hold the serial carry in a 1-bit register: loaded with c_in on start, updated with the slice carry each RUN cycle for add, held at 0 for and/not.
REQ-019 SHALL leave RUN for DONE after the cycle processing bit WIDTH-1; the counter SHALL NOT wrap or run past WIDTH-1.
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL have latency: done high on the (WIDTH+1)th rising edge after the start-sampling edge for legal ops; on the 1st edge for op=3.
REQ-022 SHALL, for op=3, produce result = 0, c_out = 0, err = 1 and skip RUN.
REQ-023 SHALL hold result, c_out and err stable from done until the next accepted start; err SHALL clear on that start.
REQ-024 SHALL drive busy = 1 iff state is RUN; no output SHALL ever be high-impedance.
REQ-025 SHALL compute add modulo 2^WIDTH with c_out = bit WIDTH of a + b + c_in.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-RUN, asynchronously force state IDLE, busy 0, done 0, result 0, c_out 0, err 0, counter 0, carry 0.
REQ-027 SHALL discard any operation in progress on reset; no done pulse SHALL follow a reset.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL place op encodings (OP_ADD=0, OP_AND=1, OP_NOT=2) and FSM state encodings in a shared package/include used by all ALU-related blocks.
REQ-030 SHALL instantiate the team's existing one-bit ALU cell (one_bit_ALU) as the single sub-module for the per-bit datapath; serial logic stays in this block.
REQ-031 SHALL size the bit counter as clog2(WIDTH) bits.

Verification (WIDTH=8)
REQ-032 SHALL cover: add a=0xFF, b=0x01, c_in=0 -> done 9 edges after start, result=0x00, c_out=1, err=0.
REQ-033 SHALL cover: and a=0xF0, b=0x3C -> result=0x30, c_out=0; not a=0xA5 -> result=0x5A, c_out=0.
REQ-034 SHALL cover: op=3 -> done 1 edge after start, err=1, result=0x00, busy never high.
REQ-035 SHALL cover: add a=0x10, b=0x20 in progress, start with op=1 asserted in cycle 3 -> ignored; result=0x30 at done.
REQ-036 SHALL cover: rst pulsed in cycle 4 of RUN -> all outputs 0 immediately, no done; next start add 0x7F+0x01, c_in=1 -> result=0x81, c_out=0.
